prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_unit_pkg.sv | 14 +
 rtl/prefetch_unit_fetch_queue.sv | 47 ++++
 rtl/prefetch_unit.sv | 115 +++++++++++
 tb/tb_prefetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package prefetch_unit_pkg;

  localparam int INSTR_STEP    = 4;
  localparam int PF_ADDR_WIDTH = 32;
  localparam int PF_DATA_WIDTH = 32;

  // Queue entry at the default widths; the top re-declares the same shape at its own widths.
  typedef struct packed {
    logic [PF_ADDR_WIDTH-1:0] pc;
    logic [PF_DATA_WIDTH-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_unit_fetch_queue.sv
// Registered FIFO of fetched {pc, data} entries with synchronous flush; no bypass path.
module fetch_queue
  import prefetch_unit_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output logic                   head_valid,
  output entry_t                 head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Sequential instruction prefetcher: credit-limited fetch requests, in-order responses
// into a small queue, redirect flush with drop counting of stale responses.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  rsp_err
);

  localparam int                    CW        = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(INSTR_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~ADDR_WIDTH'(3);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_n;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_n;
  logic [CW-1:0]         out_q, out_n, drop_q, drop_n;
  logic [CW-1:0]         out_dec, drop_dec, q_count;
  logic [CW+1:0]         credit_used;
  logic                  run_q, rsp_err_q;
  logic                  rsp_drop, rsp_live, rsp_stray;
  logic                  xfer, push, pop;
  entry_t                push_entry, head_entry;

  // Queue slots, live requests and requests still owed a discard all consume credit.
  assign credit_used    = (CW+2)'(q_count) + (CW+2)'(out_q) + (CW+2)'(drop_q);
  assign imem_req_valid = run_q && !redirect_valid && (credit_used < (CW+2)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign xfer           = imem_req_valid && imem_req_ready;

  assign rsp_drop  = imem_rsp_valid && (drop_q != '0);
  assign rsp_live  = imem_rsp_valid && (drop_q == '0) && (out_q != '0);
  assign rsp_stray = imem_rsp_valid && (drop_q == '0) && (out_q == '0);
  assign drop_dec  = drop_q - CW'(rsp_drop);
  assign out_dec   = out_q - CW'(rsp_live);

  assign push = rsp_live && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  // Live responses come back in order after the last redirect, so one running PC labels them.
  always_comb begin
    push_entry.pc   = rsp_pc_q;
    push_entry.data = imem_rsp_data;
    if (redirect_valid) begin
      pc_n     = redirect_pc & ALIGN_MSK;
      rsp_pc_n = redirect_pc & ALIGN_MSK;
      drop_n   = drop_dec + out_dec;
      out_n    = '0;
    end else begin
      pc_n     = xfer ? pc_q + STEP : pc_q;
      rsp_pc_n = rsp_live ? rsp_pc_q + STEP : rsp_pc_q;
      drop_n   = drop_dec;
      out_n    = out_dec + CW'(xfer);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      rsp_err_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      pc_q      <= pc_n;
      rsp_pc_q  <= rsp_pc_n;
      out_q     <= out_n;
      drop_q    <= drop_n;
      rsp_err_q <= rsp_err_q || rsp_stray;
      run_q     <= 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_valid (instr_valid),
    .head_entry (head_entry),
    .count      (q_count)
  );

  assign instr_data = head_entry.data;
  assign instr_pc   = head_entry.pc;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: in-order memory model with per-request latency, queue-level
// reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_prefetch_unit;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  typedef struct { logic [AW-1:0] addr; int due; bit dropped; } req_t;
  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] data; } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid, instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          rsp_err;

  logic          wrap_req_valid;
  logic [AW-1:0] wrap_req_addr;
  logic          wrap_instr_valid;
  logic [DW-1:0] wrap_instr_data;
  logic [AW-1:0] wrap_instr_pc;
  logic          wrap_rsp_err;

  always #5 clk = ~clk;

  prefetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .rsp_err(rsp_err)
  );

  prefetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(wrap_req_valid), .imem_req_ready(1'b1), .imem_req_addr(wrap_req_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data('0),
    .redirect_valid(1'b0), .redirect_pc('0),
    .instr_valid(wrap_instr_valid), .instr_ready(1'b1),
    .instr_data(wrap_instr_data), .instr_pc(wrap_instr_pc), .rsp_err(wrap_rsp_err)
  );

  bit            k_rst, k_req_ready, k_instr_ready, k_redir, k_stray;
  logic [AW-1:0] k_redir_pc;
  int            k_lat;

  req_t          pend[$];
  ent_t          mq[$];
  logic [AW-1:0] exp_pc;
  bit            exp_err, rst_prev, model_on;
  int            last_due, cyc;

  logic [AW-1:0] xfer_log[$], pop_log[$], wrap_log[$];
  int            first_xfer_cyc, first_iv_cyc;
  bit            last_rsp, last_iv, last_err, last_rv;
  int            checks, errors;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [63:0] q_at(input logic [AW-1:0] q[$], input int i);
    if (i < q.size()) return 64'(q[i]);
    return '1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit   rsp_now, exp_rv, exp_iv;
    req_t r;
    ent_t e;
    @(negedge clk);
    rst            = k_rst;
    imem_req_ready = k_req_ready;
    instr_ready    = k_instr_ready;
    redirect_valid = k_redir;
    redirect_pc    = k_redir_pc;
    rsp_now        = k_stray || (pend.size() > 0 && pend[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = (rsp_now && pend.size() > 0) ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = model_on && !rst_prev && !k_redir && (mq.size() + pend.size() < DEPTH);
    exp_iv = model_on && mq.size() > 0;
    if (model_on) begin
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, exp_pc);
      chk("instr_valid", instr_valid, exp_iv);
      if (exp_iv) begin
        chk("instr_pc", instr_pc, mq[0].pc);
        chk("instr_data", instr_data, mq[0].data);
      end
      chk("rsp_err", rsp_err, exp_err);
    end
    last_rsp = rsp_now;
    last_iv  = instr_valid;
    last_err = rsp_err;
    last_rv  = imem_req_valid;
    if (!k_rst && imem_req_valid && imem_req_ready) begin
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      xfer_log.push_back(imem_req_addr);
    end
    if (!k_rst && instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
    if (!k_rst && instr_valid && instr_ready && !redirect_valid) pop_log.push_back(instr_pc);
    if (model_on && !k_rst && wrap_req_valid && wrap_log.size() < 3) wrap_log.push_back(wrap_req_addr);
    // Reference update for the coming edge.
    if (k_rst) begin
      model_on = 1; rst_prev = 1; exp_pc = '0; exp_err = 0; last_due = 0;
      pend.delete(); mq.delete();
    end else begin
      rst_prev = 0;
      if (exp_iv && k_instr_ready && !k_redir) void'(mq.pop_front());
      if (rsp_now) begin
        if (pend.size() > 0) begin
          r = pend.pop_front();
          if (!r.dropped && !k_redir) begin
            e.pc = r.addr; e.data = mem_word(r.addr);
            mq.push_back(e);
          end
        end else exp_err = 1;
      end
      if (k_redir) begin
        mq.delete();
        foreach (pend[i]) pend[i].dropped = 1;
        exp_pc = k_redir_pc & ~32'h3;
      end else if (exp_rv && k_req_ready) begin
        r.addr = exp_pc; r.dropped = 0;
        r.due = cyc + k_lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        pend.push_back(r);
        exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic clear_logs();
    xfer_log.delete(); pop_log.delete();
    first_xfer_cyc = -1; first_iv_cyc = -1;
  endtask

  task automatic do_reset();
    k_rst = 1; k_redir = 0; k_stray = 0;
    step(); step();
    k_rst = 0;
    clear_logs();
  endtask

  initial begin
    rst = 1; imem_req_ready = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
    imem_rsp_valid = 0; imem_rsp_data = '0;
    k_lat = 1; k_redir_pc = '0; checks = 0; errors = 0; cyc = 0;
    clear_logs();

    // Streaming fetch, latency 1.
    do_reset();
    k_lat = 1; k_req_ready = 1; k_instr_ready = 1;
    repeat (10) step();
    chk("t1_addr0", q_at(xfer_log, 0), 64'h0);
    chk("t1_addr1", q_at(xfer_log, 1), 64'h4);
    chk("t1_addr2", q_at(xfer_log, 2), 64'h8);
    chk("t1_pc0", q_at(pop_log, 0), 64'h0);
    chk("t1_pc1", q_at(pop_log, 1), 64'h4);
    chk("t1_pc2", q_at(pop_log, 2), 64'h8);
    chk("t1_latency", 64'(first_iv_cyc - first_xfer_cyc), 64'd2);

    // Decode stalled: credits cap requests at DEPTH.
    do_reset();
    k_lat = 1; k_req_ready = 1; k_instr_ready = 0;
    repeat (12) step();
    chk("t2_issued", xfer_log.size(), 4);
    chk("t2_stalled", last_rv, 0);
    k_instr_ready = 1;
    repeat (3) step();
    chk("t2_resumed", xfer_log.size() > 4, 1);

    // Redirect with two outstanding, latency 3, unaligned target.
    do_reset();
    k_lat = 3; k_req_ready = 1; k_instr_ready = 1;
    for (int i = 0; i < 20 && xfer_log.size() < 2; i++) step();
    chk("t3_two_issued", xfer_log.size(), 2);
    k_redir = 1; k_redir_pc = 32'h103;
    step();
    k_redir = 0;
    clear_logs();
    repeat (12) step();
    chk("t3_new_addr", q_at(xfer_log, 0), 64'h100);
    chk("t3_first_pc", q_at(pop_log, 0), 64'h100);
    chk("t3_second_pc", q_at(pop_log, 1), 64'h104);

    // Redirect coinciding with a response and a pop.
    do_reset();
    k_lat = 2; k_req_ready = 1; k_instr_ready = 1;
    repeat (8) step();
    k_redir = 1; k_redir_pc = 32'h40;
    step();
    k_redir = 0;
    chk("t4_rsp_in_redirect", last_rsp, 1);
    chk("t4_head_in_redirect", last_iv, 1);
    clear_logs();
    step();
    chk("t4_flushed", last_iv, 0);
    repeat (10) step();
    chk("t4_first_pc", q_at(pop_log, 0), 64'h40);

    // Stray response with a full, stalled queue.
    do_reset();
    k_lat = 2; k_req_ready = 1; k_instr_ready = 0;
    repeat (8) step();
    k_req_ready = 0;
    for (int i = 0; i < 20 && pend.size() > 0; i++) step();
    chk("t5_memory_idle", pend.size(), 0);
    k_stray = 1;
    step();
    k_stray = 0;
    step();
    chk("t5_err_set", last_err, 1);
    chk("t5_queue_kept", last_iv, 1);
    k_instr_ready = 1;
    repeat (6) step();
    chk("t5_pop_count", pop_log.size(), 4);
    chk("t5_pc0", q_at(pop_log, 0), 64'h0);
    chk("t5_pc3", q_at(pop_log, 3), 64'hC);
    chk("t5_err_sticky", last_err, 1);
    do_reset();
    step();
    chk("t5_err_cleared", last_err, 0);

    // Back-to-back redirects.
    do_reset();
    k_lat = 3; k_req_ready = 1; k_instr_ready = 1;
    repeat (4) step();
    k_redir = 1; k_redir_pc = 32'h200;
    step();
    k_redir_pc = 32'h300;
    step();
    k_redir = 0;
    clear_logs();
    repeat (14) step();
    chk("t6_new_addr", q_at(xfer_log, 0), 64'h300);
    chk("t6_first_pc", q_at(pop_log, 0), 64'h300);
    chk("t6_second_pc", q_at(pop_log, 1), 64'h304);

    // PC wrap from RESET_PC near the top of the address space.
    chk("wrap_addr0", q_at(wrap_log, 0), 64'hFFFF_FFF8);
    chk("wrap_addr1", q_at(wrap_log, 1), 64'hFFFF_FFFC);
    chk("wrap_addr2", q_at(wrap_log, 2), 64'h0);
    chk("wrap_head_idle", wrap_instr_valid ? {wrap_instr_pc, wrap_instr_data} : 64'h0, 64'h0);
    chk("wrap_no_err", wrap_rsp_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
